barrel_rotator_left_core: RTL and testbench

BARREL_ROTATOR_LEFT_CORE -- requirements
Module: barrel_rotator_left

---
 rtl/barrel_rotator_left_core.sv | 110 +++++++++++
 tb/tb_barrel_rotator_left_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/barrel_rotator_left_core.sv
// Circular left rotator built from log2(WIDTH) shift-by-2^k stages with a registered result.
// Define BARREL_ROTATOR_LEFT_PIPELINE_EN to register data and valid after every stage.
module barrel_rotator_left_core #(
    parameter int WIDTH = 8,
    localparam int WIDTH_LOG2 = $clog2(WIDTH)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [WIDTH_LOG2-1:0] rotation,
    input  logic                  valid_in,
    output logic [WIDTH-1:0]      data_out,
    output logic                  valid_out
);

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $fatal(1, "barrel_rotator_left_core: WIDTH must be a power of two >= 2");
        end
    endgenerate

    // Shift amount is always a stage constant, so this reduces to wiring.
    function automatic logic [WIDTH-1:0] rotl_const(input logic [WIDTH-1:0] x,
                                                    input int unsigned    s);
        return (x << s) | (x >> (WIDTH - s));
    endfunction

    logic [WIDTH-1:0] w_stage [WIDTH_LOG2+1];

    assign w_stage[0] = data_in;

`ifdef BARREL_ROTATOR_LEFT_PIPELINE_EN

    logic [WIDTH_LOG2-1:0] w_rot [WIDTH_LOG2];
    logic [WIDTH_LOG2:0]   w_vld;

    assign w_rot[0] = rotation;
    assign w_vld[0] = valid_in;

    for (genvar k = 0; k < WIDTH_LOG2; k++) begin : g_stage
        logic [WIDTH-1:0] w_next;
        logic [WIDTH-1:0] r_data;
        logic             r_valid;

        // Rotation travels with its operand; bit 0 always selects the current stage.
        assign w_next = w_rot[k][0] ? rotl_const(w_stage[k], 1 << k) : w_stage[k];

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_vld[k];
                if (w_vld[k]) begin
                    r_data <= w_next;
                end
            end
        end

        assign w_stage[k+1] = r_data;
        assign w_vld[k+1]   = r_valid;

        if (k < WIDTH_LOG2 - 1) begin : g_rot
            logic [WIDTH_LOG2-1:0] r_rot;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_rot <= '0;
                end else if (w_vld[k]) begin
                    r_rot <= w_rot[k] >> 1;
                end
            end

            assign w_rot[k+1] = r_rot;
        end else begin : g_last
            logic w_unused_rot;
            assign w_unused_rot = ^w_rot[k];
        end
    end

    assign data_out  = w_stage[WIDTH_LOG2];
    assign valid_out = w_vld[WIDTH_LOG2];

`else

    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;

    for (genvar k = 0; k < WIDTH_LOG2; k++) begin : g_stage
        assign w_stage[k+1] = rotation[k] ? rotl_const(w_stage[k], 1 << k) : w_stage[k];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= valid_in;
            if (valid_in) begin
                r_data_out <= w_stage[WIDTH_LOG2];
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;

`endif

endmodule

// File: tb/tb_barrel_rotator_left_core.sv
// Scoreboard bench for barrel_rotator_left_core at WIDTH=8, either build configuration.
module tb_barrel_rotator_left_core;

    localparam int WIDTH = 8;
`ifdef BARREL_ROTATOR_LEFT_PIPELINE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [7:0] d;
        int         c;
        int         tag;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic [7:0] data_in;
    logic [2:0] rotation;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;

    int   cyc;
    int   n_vec;
    int   n_err;
    int   tag_cnt;
    exp_t sb [$];

    logic [7:0] sweep_exp [8];

    barrel_rotator_left_core #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .data_in   (data_in),
        .rotation  (rotation),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: result[i] = d[(i - r) mod 8].
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input int r);
        logic [7:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i] = d[(i - r + 8) % 8];
        end
        return res;
    endfunction

    task automatic issue(input logic [7:0] d, input logic [2:0] r, input logic [7:0] e);
        exp_t x;
        @(posedge clock);
        #1;
        data_in  = d;
        rotation = r;
        valid_in = 1'b1;
        x.d   = e;
        x.c   = cyc + LAT;
        x.tag = tag_cnt;
        tag_cnt++;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Monitor: every valid_out must match the oldest pending expectation and its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resetn && valid_out) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: data_out=%h valid_out=1, required no output",
                             data_out);
                end else begin
                    e = sb.pop_front();
                    if (data_out !== e.d || cyc != e.c) begin
                        n_err++;
                        $display("FAIL result_%0d: data_out=%h at cycle %0d, required %h at cycle %0d",
                                 e.tag, data_out, cyc, e.d, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [2:0] r;
        cyc      = 0;
        n_vec    = 0;
        n_err    = 0;
        tag_cnt  = 0;
        resetn   = 1'b0;
        data_in  = '0;
        rotation = '0;
        valid_in = 1'b0;
        sweep_exp = '{8'h99, 8'h33, 8'h66, 8'hCC, 8'h99, 8'h33, 8'h66, 8'hCC};

        repeat (3) @(posedge clock);
        #1;
        check8("reset_data_out", data_out, 8'h00);
        check8("reset_valid_out", {7'd0, valid_out}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;

        // Sweep of 8'h99 through every rotation amount, back to back.
        for (int i = 0; i < 8; i++) begin
            r = 3'(i);
            issue(8'h99, r, sweep_exp[i]);
        end
        drain();

        // Wrap-around in both directions.
        issue(8'h80, 3'd1, 8'h01);
        issue(8'h01, 3'd7, 8'h80);
        drain();

        // Hold: output keeps the last result while nothing new arrives.
        issue(8'h99, 3'd3, 8'hCC);
        drain();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check8("hold_data_out", data_out, 8'hCC);
            check8("hold_valid_out", {7'd0, valid_out}, 8'h00);
        end

        // Back-to-back with distinct rotations.
        issue(8'hA5, 3'd1, 8'h4B);
        issue(8'hA5, 3'd2, 8'h96);
        issue(8'hA5, 3'd3, 8'h2D);
        drain();

        // Reset while 8'hFF rot 3 is in flight; it must never appear.
        @(posedge clock);
        #1;
        data_in  = 8'hFF;
        rotation = 3'd3;
        valid_in = 1'b1;
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        check8("midreset_data_out", data_out, 8'h00);
        check8("midreset_valid_out", {7'd0, valid_out}, 8'h00);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        idle(6);
        issue(8'h0F, 3'd2, 8'h3C);
        drain();

        // Random traffic with occasional bubbles against the reference model.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            d = 8'($urandom);
            r = 3'($urandom_range(0, 7));
            issue(d, r, ref_rot(d, int'(r)));
        end
        drain();

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
